// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared definitions for the MEM pipeline stage: bus widths, the mem_size
// encoding and packed views of the EX-to-MEM and MEM-to-WB buses.
// Ports: none (package).
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 175;
    localparam int MS_TO_WS_BUS_WD = 168;
    localparam int MS_FORWARD_WD   = 40;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

    // Field order is MSB first, matching the flat bus produced by EX.
    typedef struct packed {
        logic [31:0] pc;
        logic        ertn;
        logic [4:0]  dest;
        logic        gr_we;
        logic        res_from_csr;
        logic        res_from_mem;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic [1:0]  addr_low;
        logic [31:0] alu_result;
        logic        mem_req_issued;
        logic        excp;
        logic [15:0] excp_num;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
    } es_to_ms_bus_t;

    // Field order is MSB first, matching the flat bus consumed by WB.
    typedef struct packed {
        logic [31:0] pc;
        logic        ertn;
        logic [4:0]  dest;
        logic        gr_we;
        logic        res_from_csr;
        logic [31:0] final_result;
        logic        excp;
        logic [15:0] excp_num;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
    } ms_to_ws_bus_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align
// Combinational load-data formatter: selects the addressed byte or halfword
// from the 32-bit read word and zero- or sign-extends it.
// Ports:
//   rdata        in  32  raw read word (SRAM response or buffered copy)
//   mem_size     in  2   0 = byte, 1 = half, 2 = word
//   mem_unsigned in  1   zero-extend when set, sign-extend otherwise
//   addr_low     in  2   low address bits selecting the lane
//   load_data    out 32  aligned and extended result
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [1:0]  addr_low,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_low)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_low[1] ? rdata[31:16] : rdata[15:0];

        // The unused encoding 3 falls through to a plain word load.
        case (mem_size)
            MEM_SIZE_BYTE: load_data = {{24{~mem_unsigned & byte_sel[7]}}, byte_sel};
            MEM_SIZE_HALF: load_data = {{16{~mem_unsigned & half_sel[15]}}, half_sel};
            default:       load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// Fourth pipeline stage. Holds one instruction from EX, waits for the
// data-SRAM response of any access it issued, formats load data and hands
// the result to WB. Responses belonging to flushed instructions are counted
// and dropped.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   es_to_ms_valid, es_to_ms_bus     instruction from EX (175 bits)
//   ms_allowin                       MEM can accept from EX
//   ws_allowin                       WB can accept
//   ms_to_ws_valid, ms_to_ws_bus     result to WB (168 bits)
//   data_sram_req, data_sram_addr_ok request handshake observed from EX
//   data_sram_data_ok, data_sram_rdata  data response
//   flush                            exception / ertn flush from WB
//   ms_ex                            MEM holds an exception or ertn
//   ms_forward                       {valid, gr_we, dest, result, load_wait}
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_req,
    input  logic                       data_sram_addr_ok,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       flush,
    output logic                       ms_ex,
    output logic [MS_FORWARD_WD-1:0]   ms_forward
);

    logic          ms_valid_q, ms_valid_d;
    es_to_ms_bus_t es_bus_q, es_bus_d;
    logic [1:0]    outstanding_q, outstanding_d;
    logic [1:0]    discard_q, discard_d;
    logic [31:0]   data_buf_q, data_buf_d;
    logic          buf_vld_q, buf_vld_d;

    logic          issue;
    logic          resp_accept;
    logic          need_data;
    logic          ms_ready_go;
    logic          ms_leave;
    logic          ms_load_wait;
    logic [31:0]   load_rd;
    logic [31:0]   load_data;
    logic [31:0]   final_result;
    ms_to_ws_bus_t ws_bus;

    // Handshake and stall logic. A response is only ours when nothing is
    // left to discard; once the buffer holds it, the stage no longer waits.
    always_comb begin
        issue          = data_sram_req & data_sram_addr_ok;
        resp_accept    = data_sram_data_ok & (discard_q == 2'd0);
        need_data      = ms_valid_q & es_bus_q.mem_req_issued & ~es_bus_q.excp;
        ms_ready_go    = ~need_data | buf_vld_q | resp_accept;
        ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
        ms_to_ws_valid = ms_valid_q & ms_ready_go & ~flush;
        ms_leave       = ms_valid_q & ms_ready_go & ws_allowin;
        ms_load_wait   = ms_valid_q & es_bus_q.res_from_mem & ~ms_ready_go;
        ms_ex          = ms_valid_q & (es_bus_q.excp | es_bus_q.ertn);
    end

    // Next-state for the valid bit, the bus register and the transaction
    // counters. Counters saturate so a protocol violation cannot wrap them;
    // on flush every transaction still in flight after this cycle becomes
    // one to throw away.
    always_comb begin
        ms_valid_d = ms_valid_q;
        if (flush) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end

        es_bus_d = es_bus_q;
        if (es_to_ms_valid & ms_allowin) begin
            es_bus_d = es_to_ms_bus_t'(es_to_ms_bus);
        end

        outstanding_d = outstanding_q;
        case ({issue, data_sram_data_ok})
            2'b10: if (outstanding_q != 2'd2) outstanding_d = outstanding_q + 2'd1;
            2'b01: if (outstanding_q != 2'd0) outstanding_d = outstanding_q - 2'd1;
            default: outstanding_d = outstanding_q;
        endcase

        discard_d = discard_q;
        if (flush) begin
            discard_d = outstanding_d;
        end else if (data_sram_data_ok & (discard_q != 2'd0)) begin
            discard_d = discard_q - 2'd1;
        end
    end

    // Response buffer. Data that arrives while WB is blocked must be kept,
    // because the SRAM will not present it again.
    always_comb begin
        buf_vld_d  = buf_vld_q;
        data_buf_d = data_buf_q;
        if (flush | ms_leave) begin
            buf_vld_d = 1'b0;
        end else if (resp_accept & need_data & ~buf_vld_q & ~ws_allowin) begin
            buf_vld_d  = 1'b1;
            data_buf_d = data_sram_rdata;
        end
    end

    // Control state with reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q    <= 1'b0;
            outstanding_q <= 2'd0;
            discard_q     <= 2'd0;
            buf_vld_q     <= 1'b0;
        end else begin
            ms_valid_q    <= ms_valid_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            buf_vld_q     <= buf_vld_d;
        end
    end

    // Datapath state; its contents only matter while the valid bits say so.
    always_ff @(posedge clk) begin
        es_bus_q   <= es_bus_d;
        data_buf_q <= data_buf_d;
    end

    // Protocol checks: a response with nothing in flight, or a third
    // request while two are already outstanding.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(data_sram_data_ok && (outstanding_q == 2'd0)));
            assert (!(issue && !data_sram_data_ok && (outstanding_q == 2'd2)));
        end
    end

    assign load_rd = buf_vld_q ? data_buf_q : data_sram_rdata;

    load_align u_load_align (
        .rdata        (load_rd),
        .mem_size     (es_bus_q.mem_size),
        .mem_unsigned (es_bus_q.mem_unsigned),
        .addr_low     (es_bus_q.addr_low),
        .load_data    (load_data)
    );

    // Output bus assembly; everything except the result passes straight through.
    always_comb begin
        final_result        = es_bus_q.res_from_mem ? load_data : es_bus_q.alu_result;
        ws_bus.pc           = es_bus_q.pc;
        ws_bus.ertn         = es_bus_q.ertn;
        ws_bus.dest         = es_bus_q.dest;
        ws_bus.gr_we        = es_bus_q.gr_we;
        ws_bus.res_from_csr = es_bus_q.res_from_csr;
        ws_bus.final_result = final_result;
        ws_bus.excp         = es_bus_q.excp;
        ws_bus.excp_num     = es_bus_q.excp_num;
        ws_bus.csr_we       = es_bus_q.csr_we;
        ws_bus.csr_num      = es_bus_q.csr_num;
        ws_bus.csr_wmask    = es_bus_q.csr_wmask;
        ws_bus.csr_wdata    = es_bus_q.csr_wdata;
    end

    assign ms_to_ws_bus = ws_bus;
    assign ms_forward   = {ms_valid_q, es_bus_q.gr_we, es_bus_q.dest, final_result, ms_load_wait};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// Directed bench for mem_stage: loads of each size, delayed responses,
// stores, flush with responses in flight, WB back-pressure and exception
// pass-through. Expected values are written out by hand.
module tb_mem_stage;

   logic         clk;
   logic         reset;
   logic         esToMsValid;
   logic [174:0] esToMsBus;
   logic         msAllowin;
   logic         wsAllowin;
   logic         msToWsValid;
   logic [167:0] msToWsBus;
   logic         dataSramReq;
   logic         dataSramAddrOk;
   logic         dataSramDataOk;
   logic [31:0]  dataSramRdata;
   logic         flush;
   logic         msEx;
   logic [39:0]  msForward;

   int vecCnt = 0;
   int miscompareCnt = 0;

   mem_stage dut (
      .clk               (clk),
      .reset             (reset),
      .es_to_ms_valid    (esToMsValid),
      .es_to_ms_bus      (esToMsBus),
      .ms_allowin        (msAllowin),
      .ws_allowin        (wsAllowin),
      .ms_to_ws_valid    (msToWsValid),
      .ms_to_ws_bus      (msToWsBus),
      .data_sram_req     (dataSramReq),
      .data_sram_addr_ok (dataSramAddrOk),
      .data_sram_data_ok (dataSramDataOk),
      .data_sram_rdata   (dataSramRdata),
      .flush             (flush),
      .ms_ex             (msEx),
      .ms_forward        (msForward)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Full EX-to-MEM bus, fields MSB first.
   function automatic logic [174:0] esBus(
      input logic [31:0] pc, input logic ertn, input logic [4:0] dest,
      input logic grWe, input logic resCsr, input logic resMem,
      input logic [1:0] size, input logic uns, input logic [31:0] alu,
      input logic issued, input logic excp, input logic [15:0] excpNum,
      input logic csrWe, input logic [13:0] csrNum,
      input logic [31:0] wmask, input logic [31:0] wdata);
      return {pc, ertn, dest, grWe, resCsr, resMem, size, uns, alu[1:0], alu,
              issued, excp, excpNum, csrWe, csrNum, wmask, wdata};
   endfunction

   // Plain memory or ALU instruction with no CSR or exception content.
   function automatic logic [174:0] memBus(
      input logic [31:0] pc, input logic [4:0] dest, input logic grWe,
      input logic resMem, input logic [1:0] size, input logic uns,
      input logic [31:0] alu, input logic issued);
      return esBus(pc, 1'b0, dest, grWe, 1'b0, resMem, size, uns, alu, issued,
                   1'b0, 16'h0, 1'b0, 14'h0, 32'h0, 32'h0);
   endfunction

   // Full MEM-to-WB bus, fields MSB first.
   function automatic logic [167:0] wsBus(
      input logic [31:0] pc, input logic ertn, input logic [4:0] dest,
      input logic grWe, input logic resCsr, input logic [31:0] result,
      input logic excp, input logic [15:0] excpNum, input logic csrWe,
      input logic [13:0] csrNum, input logic [31:0] wmask, input logic [31:0] wdata);
      return {pc, ertn, dest, grWe, resCsr, result, excp, excpNum, csrWe, csrNum, wmask, wdata};
   endfunction

   // Drive every input with blocking assignments, then let logic settle.
   task automatic applyStimulus(input logic v, input logic [174:0] bus,
                                input logic req, input logic aok, input logic dok,
                                input logic [31:0] rdata, input logic wsa, input logic fl);
      esToMsValid    = v;
      esToMsBus      = bus;
      dataSramReq    = req;
      dataSramAddrOk = aok;
      dataSramDataOk = dok;
      dataSramRdata  = rdata;
      wsAllowin      = wsa;
      flush          = fl;
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [167:0] actual, input logic [167:0] expected);
      vecCnt++;
      if (actual !== expected) begin
         miscompareCnt++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Load that enters MEM with its request and gets its response in the
   // first MEM cycle.
   task automatic runLoad(input string tag, input logic [174:0] bus,
                          input logic [31:0] rdata, input logic [31:0] expFinal);
      applyStimulus(1'b1, bus, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput({tag, "_allowin"}, msAllowin, 1);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, rdata, 1'b1, 1'b0);
      checkOutput({tag, "_valid"}, msToWsValid, 1);
      checkOutput({tag, "_final"}, msToWsBus[127:96], expFinal);
      tick();
   endtask

   logic [174:0] busA;
   logic [174:0] busB;

   initial begin
      reset = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle();
      checkOutput("reset_valid", msToWsValid, 0);
      checkOutput("reset_allowin", msAllowin, 1);
      checkOutput("reset_ex", msEx, 0);
      checkOutput("reset_fwd_valid", msForward[39], 0);
      checkOutput("reset_fwd_wait", msForward[0], 0);

      // Word load with same-cycle response.
      busA = memBus(32'h1c00_0000, 5'd5, 1'b1, 1'b1, 2'd2, 1'b0, 32'h100, 1'b1);
      applyStimulus(1'b1, busA, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("word_allowin", msAllowin, 1);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h8765_4321, 1'b1, 1'b0);
      checkOutput("word_valid", msToWsValid, 1);
      checkOutput("word_bus", msToWsBus,
                  wsBus(32'h1c00_0000, 1'b0, 5'd5, 1'b1, 1'b0, 32'h8765_4321,
                        1'b0, 16'h0, 1'b0, 14'h0, 32'h0, 32'h0));
      checkOutput("word_fwd", msForward, {1'b1, 1'b1, 5'd5, 32'h8765_4321, 1'b0});
      tick();
      idle();
      checkOutput("word_after_valid", msToWsValid, 0);

      // Byte and halfword extraction with both extensions.
      runLoad("ldb_s", memBus(32'h1c00_0004, 5'd6, 1'b1, 1'b1, 2'd0, 1'b0, 32'h103, 1'b1),
              32'h80FF_FFFF, 32'hFFFF_FF80);
      runLoad("ldb_u", memBus(32'h1c00_0008, 5'd6, 1'b1, 1'b1, 2'd0, 1'b1, 32'h103, 1'b1),
              32'h80FF_FFFF, 32'h0000_0080);
      runLoad("ldb_s1", memBus(32'h1c00_000c, 5'd6, 1'b1, 1'b1, 2'd0, 1'b0, 32'h101, 1'b1),
              32'h0000_7F00, 32'h0000_007F);
      runLoad("ldh_s", memBus(32'h1c00_0010, 5'd6, 1'b1, 1'b1, 2'd1, 1'b0, 32'h102, 1'b1),
              32'h8001_1234, 32'hFFFF_8001);
      runLoad("ldh_u", memBus(32'h1c00_0014, 5'd6, 1'b1, 1'b1, 2'd1, 1'b1, 32'h100, 1'b1),
              32'h0000_F00F, 32'h0000_F00F);

      // Load whose response comes three cycles late.
      busA = memBus(32'h1c00_0018, 5'd7, 1'b1, 1'b1, 2'd2, 1'b0, 32'h200, 1'b1);
      applyStimulus(1'b1, busA, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         idle();
         checkOutput($sformatf("delay_allowin%0d", i), msAllowin, 0);
         checkOutput($sformatf("delay_wait%0d", i), msForward[0], 1);
         checkOutput($sformatf("delay_valid%0d", i), msToWsValid, 0);
         tick();
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
      checkOutput("delay_done_valid", msToWsValid, 1);
      checkOutput("delay_done_final", msToWsBus[127:96], 32'h1234_5678);
      checkOutput("delay_done_wait", msForward[0], 0);
      tick();
      idle();
      checkOutput("delay_after_valid", msToWsValid, 0);

      // Store waits for its response but reports the ALU result.
      busA = memBus(32'h1c00_001c, 5'd0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h300, 1'b1);
      applyStimulus(1'b1, busA, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      idle();
      checkOutput("st_wait_allowin", msAllowin, 0);
      checkOutput("st_wait_loadwait", msForward[0], 0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
      checkOutput("st_valid", msToWsValid, 1);
      checkOutput("st_final", msToWsBus[127:96], 32'h300);
      tick();

      // Flush with two transactions in flight; both responses are dropped.
      busA = memBus(32'h1c00_0020, 5'd8, 1'b1, 1'b1, 2'd2, 1'b0, 32'h400, 1'b1);
      busB = memBus(32'h1c00_0024, 5'd9, 1'b1, 1'b1, 2'd2, 1'b0, 32'h404, 1'b1);
      applyStimulus(1'b1, busA, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, busB, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("fl_stall_allowin", msAllowin, 0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("fl_flush_valid", msToWsValid, 0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hBADB_AD00, 1'b1, 1'b0);
      checkOutput("fl_drop1_valid", msToWsValid, 0);
      checkOutput("fl_drop1_allowin", msAllowin, 1);
      tick();
      busA = memBus(32'h1c00_0030, 5'd9, 1'b1, 1'b1, 2'd2, 1'b0, 32'h500, 1'b1);
      applyStimulus(1'b1, busA, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hBADB_AD01, 1'b1, 1'b0);
      checkOutput("fl_drop2_valid", msToWsValid, 0);
      checkOutput("fl_drop2_wait", msForward[0], 1);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0);
      checkOutput("fl_third_valid", msToWsValid, 1);
      checkOutput("fl_third_final", msToWsBus[127:96], 32'hCAFE_F00D);
      tick();

      // Flush beats a same-cycle load from EX.
      busA = memBus(32'h1c00_0040, 5'd10, 1'b1, 1'b0, 2'd2, 1'b0, 32'h77, 1'b0);
      applyStimulus(1'b1, busA, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      tick();
      idle();
      checkOutput("flprio_valid", msToWsValid, 0);
      applyStimulus(1'b1, busA, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      idle();
      checkOutput("alu_valid", msToWsValid, 1);
      checkOutput("alu_final", msToWsBus[127:96], 32'h77);
      tick();

      // WB blocked when the response arrives: data is held in the buffer.
      busA = memBus(32'h1c00_0050, 5'd11, 1'b1, 1'b1, 2'd2, 1'b0, 32'h600, 1'b1);
      applyStimulus(1'b1, busA, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h1357_9BDF, 1'b0, 1'b0);
      checkOutput("buf_cap_valid", msToWsValid, 1);
      checkOutput("buf_cap_allowin", msAllowin, 0);
      tick();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 32'h1111_1111, 1'b0, 1'b0);
         checkOutput($sformatf("buf_hold_final%0d", i), msToWsBus[127:96], 32'h1357_9BDF);
         checkOutput($sformatf("buf_hold_allowin%0d", i), msAllowin, 0);
         tick();
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 32'h1111_1111, 1'b1, 1'b0);
      checkOutput("buf_rel_valid", msToWsValid, 1);
      checkOutput("buf_rel_final", msToWsBus[127:96], 32'h1357_9BDF);
      checkOutput("buf_rel_allowin", msAllowin, 1);
      tick();
      idle();
      checkOutput("buf_after_valid", msToWsValid, 0);

      // Exception (ALE) instruction: no wait, fields pass through.
      busA = esBus(32'h1c00_0060, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h601, 1'b1,
                   1'b1, 16'h0040, 1'b1, 14'h0006, 32'hFFFF_0000, 32'h1234_5678);
      applyStimulus(1'b1, busA, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      idle();
      checkOutput("excp_valid", msToWsValid, 1);
      checkOutput("excp_ms_ex", msEx, 1);
      checkOutput("excp_bus", msToWsBus,
                  wsBus(32'h1c00_0060, 1'b0, 5'd12, 1'b1, 1'b0, 32'h601,
                        1'b1, 16'h0040, 1'b1, 14'h0006, 32'hFFFF_0000, 32'h1234_5678));
      tick();
      idle();
      checkOutput("excp_after_ex", msEx, 0);

      // ertn with a CSR-sourced result raises ms_ex and passes through.
      busA = esBus(32'h1c00_0070, 1'b1, 5'd13, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h42, 1'b0,
                   1'b0, 16'h0, 1'b0, 14'h0, 32'h0, 32'h0);
      applyStimulus(1'b1, busA, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      idle();
      checkOutput("ertn_ms_ex", msEx, 1);
      checkOutput("ertn_bus", msToWsBus,
                  wsBus(32'h1c00_0070, 1'b1, 5'd13, 1'b1, 1'b1, 32'h42,
                        1'b0, 16'h0, 1'b0, 14'h0, 32'h0, 32'h0));
      tick();

      // Reset while a load waits in MEM empties the stage.
      busA = memBus(32'h1c00_0080, 5'd14, 1'b1, 1'b1, 2'd2, 1'b0, 32'h700, 1'b1);
      applyStimulus(1'b1, busA, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      idle();
      checkOutput("rst_mid_wait", msForward[0], 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle();
      checkOutput("rst_mid_valid", msToWsValid, 0);
      checkOutput("rst_mid_fwd", msForward[39], 0);
      checkOutput("rst_mid_allowin", msAllowin, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecCnt, miscompareCnt);
      $finish;
   end

endmodule
